// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed hex display scanner.
package seg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a}; dp bit kept high here, decoder overrides it.
  localparam logic [15:0][7:0] GLYPH = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/seg_hex_dec.sv
// Combinational hex nibble to active-low 7-segment decoder with decimal point.
module seg_hex_dec
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_dp,
  output logic [7:0] o_seg_n
);

  logic [7:0] w_glyph;

  assign w_glyph = GLYPH[i_nibble];
  assign o_seg_n = {~i_dp, w_glyph[6:0]};

endmodule

// File: rtl/seg_scan.sv
// Multiplexed hex display scanner with a frame-synchronous pending/display word pair.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned NDIG = 8,
  parameter int unsigned DIV  = 1000,
  parameter int unsigned GAP  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] in_data,
  input  logic [NDIG-1:0]   in_dp,
  output logic [7:0]        seg_n,
  output logic [NDIG-1:0]   an_n
);

  localparam int unsigned CMax = (DIV > GAP) ? DIV : GAP;
  localparam int unsigned CW   = $clog2(CMax);
  localparam int unsigned IW   = $clog2(NDIG);

  localparam logic [CW-1:0] DivLast = CW'(DIV - 1);
  localparam logic [CW-1:0] GapLast = CW'(GAP - 1);
  localparam logic [IW-1:0] IdxLast = IW'(NDIG - 1);

  state_t            r_state, w_state_d;
  logic [CW-1:0]     r_cnt, w_cnt_d;
  logic [IW-1:0]     r_idx, w_idx_d;
  logic [4*NDIG-1:0] r_disp_data, r_pend_data;
  logic [NDIG-1:0]   r_disp_dp, r_pend_dp;
  logic              r_pend_full;
  logic [7:0]        r_seg_n, w_seg_d;
  logic [NDIG-1:0]   r_an_n, w_an_d;

  logic              w_boundary;
  logic              w_xfer;
  logic [3:0]        w_nib;
  logic              w_dp;
  logic [7:0]        w_dec_seg_n;
  logic              w_blank_lz;

  assign in_ready   = ~r_pend_full;
  assign w_xfer     = in_valid & in_ready;
  assign w_boundary = (r_state == SHOW) && (r_cnt == DivLast) && (r_idx == IdxLast);
  assign w_nib      = r_disp_data[{r_idx, 2'b00} +: 4];
  assign w_dp       = r_disp_dp[r_idx];

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt + 1'b1;
    w_idx_d   = r_idx;
    unique case (r_state)
      BLANK: begin
        if (r_cnt == GapLast) begin
          w_state_d = SHOW;
          w_cnt_d   = '0;
        end
      end
      SHOW: begin
        if (r_cnt == DivLast) begin
          w_state_d = BLANK;
          w_cnt_d   = '0;
          w_idx_d   = (r_idx == IdxLast) ? '0 : r_idx + 1'b1;
        end
      end
      default: begin
        w_state_d = BLANK;
        w_cnt_d   = '0;
      end
    endcase
  end

`ifdef SEG_SCAN_LZB_EN
  logic [NDIG-1:0] w_hi_zero;

  // w_hi_zero[i]: nibble i and every nibble above it are zero.
  always_comb begin
    logic acc;
    acc       = 1'b1;
    w_hi_zero = '0;
    for (int i = int'(NDIG) - 1; i >= 0; i--) begin
      acc          = acc & (r_disp_data[4*i +: 4] == 4'h0);
      w_hi_zero[i] = acc;
    end
  end

  assign w_blank_lz = (r_idx != '0) && w_hi_zero[r_idx] && !w_dp;
`else
  assign w_blank_lz = 1'b0;
`endif

  seg_hex_dec u_dec (
    .i_nibble (w_nib),
    .i_dp     (w_dp),
    .o_seg_n  (w_dec_seg_n)
  );

  always_comb begin
    w_seg_d = SEG_OFF;
    w_an_d  = '1;
    if (r_state == SHOW) begin
      w_an_d[r_idx] = 1'b0;
      w_seg_d       = w_blank_lz ? SEG_OFF : w_dec_seg_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= BLANK;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_disp_data <= '0;
      r_disp_dp   <= '0;
      r_pend_data <= '0;
      r_pend_dp   <= '0;
      r_pend_full <= 1'b0;
      r_seg_n     <= SEG_OFF;
      r_an_n      <= '1;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_idx   <= w_idx_d;
      r_seg_n <= w_seg_d;
      r_an_n  <= w_an_d;
      // Commit only at the frame boundary so a frame never mixes two words.
      if (w_boundary && r_pend_full) begin
        r_disp_data <= r_pend_data;
        r_disp_dp   <= r_pend_dp;
        r_pend_full <= 1'b0;
      end else if (w_xfer) begin
        r_pend_data <= in_data;
        r_pend_dp   <= in_dp;
        r_pend_full <= 1'b1;
      end
    end
  end

  assign seg_n = r_seg_n;
  assign an_n  = r_an_n;

endmodule

// File: tb/tb_seg_scan.sv
// Randomized self-checking bench for seg_scan against a frame-timeline reference model.
module tb_seg_scan;

  localparam int NDIG   = 4;
  localparam int DIV    = 4;
  localparam int GAP    = 2;
  localparam int SLOT   = GAP + DIV;
  localparam int PERIOD = NDIG * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [3:0]  in_dp = '0;
  logic [7:0]  seg_n;
  logic [3:0]  an_n;

  always #5 clk = ~clk;

  seg_scan #(
    .NDIG (NDIG),
    .DIV  (DIV),
    .GAP  (GAP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_dp    (in_dp),
    .seg_n    (seg_n),
    .an_n     (an_n)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: cycle index since reset release, display and pending words.
  int          m_n = 0;
  logic [15:0] m_disp = '0, m_pend = '0;
  logic [3:0]  m_disp_dp = '0, m_pend_dp = '0;
  bit          m_full = 1'b0;
  int          n_xfer = 0;

  logic [7:0] hex_glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_an(input int pos);
    if ((pos % SLOT) < GAP) return 4'hF;
    return ~(4'b0001 << (pos / SLOT));
  endfunction

  function automatic logic [7:0] exp_seg(input int pos);
    int         d;
    logic [3:0] nib;
    logic [7:0] g;
    if ((pos % SLOT) < GAP) return 8'hFF;
    d   = pos / SLOT;
    nib = m_disp[4*d +: 4];
`ifdef SEG_SCAN_LZB_EN
    if (d > 0 && (m_disp >> (4*d)) == 16'h0 && m_disp_dp[d] == 1'b0) return 8'hFF;
`endif
    g = hex_glyph[nib];
    return {~m_disp_dp[d], g[6:0]};
  endfunction

  task automatic model_reset();
    m_n       = 0;
    m_disp    = '0;
    m_disp_dp = '0;
    m_pend    = '0;
    m_pend_dp = '0;
    m_full    = 1'b0;
  endtask

  // One clock: expectations come from the cycle being left, model updates after the edge.
  task automatic step();
    int         pos;
    logic [3:0] ean;
    logic [7:0] eseg;
    bit         xfer;
    pos  = m_n % PERIOD;
    ean  = exp_an(pos);
    eseg = exp_seg(pos);
    xfer = in_valid && !m_full;
    @(posedge clk);
    #1;
    if (pos == PERIOD - 1 && m_full) begin
      m_disp    = m_pend;
      m_disp_dp = m_pend_dp;
      m_full    = 1'b0;
    end else if (xfer) begin
      m_pend    = in_data;
      m_pend_dp = in_dp;
      m_full    = 1'b1;
      n_xfer++;
    end
    m_n++;
    check("an_n", 32'(an_n), 32'(ean));
    check("seg_n", 32'(seg_n), 32'(eseg));
    check("in_ready", 32'(in_ready), 32'(!m_full));
    check("an_one_low", 32'($countones(~an_n) <= 1), 32'd1);
  endtask

  task automatic rand_word();
    logic [15:0] mask;
    mask    = 16'hFFFF >> (4 * $urandom_range(0, 4));
    in_data = 16'($urandom) & mask;
    in_dp   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
  endtask

  initial begin
    int start_x;
    int guard;

    #12;
    check("rst_an_n", 32'(an_n), 32'hF);
    check("rst_seg_n", 32'(seg_n), 32'hFF);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Leading blank then digit 0 showing "0".
    repeat (5) step();

    in_valid = 1'b1;
    in_data  = 16'h12AF;
    in_dp    = 4'h0;
    step();
    // Hold a second word while pending is full.
    in_data  = 16'h5555;
    start_x  = n_xfer;
    guard    = 0;
    while (n_xfer == start_x && guard < 100) begin
      step();
      guard++;
    end
    check("bp_one_xfer", 32'(n_xfer - start_x), 32'd1);
    in_valid = 1'b0;
    repeat (3 * PERIOD) step();

    // Randomized traffic over several frames.
    repeat (8 * PERIOD) begin
      in_valid = ($urandom_range(0, 2) == 0);
      rand_word();
      step();
    end
    in_valid = 1'b0;
    repeat (PERIOD) step();

    // Reset mid-frame during digit 2 SHOW with a full pending word.
    in_valid = 1'b1;
    guard    = 0;
    while (!(m_full && (m_n % PERIOD) == 2 * SLOT + GAP + 1) && guard < 200) begin
      rand_word();
      in_data[15:12] = 4'h9;
      step();
      guard++;
    end
    check("reach_d2_full", 32'(guard < 200), 32'd1);
    in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_an_n", 32'(an_n), 32'hF);
    check("mid_rst_seg_n", 32'(seg_n), 32'hFF);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2 * PERIOD) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 SHALL have parameter NDIG, default 8: number of multiplexed hex digits (2..8).
REQ-002 SHALL have parameter DIV, default 1000: clk cycles each digit is driven (>=2).
REQ-003 SHALL have parameter GAP, default 16: all-off clk cycles before each digit (>=1, anti-ghosting).
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1: upstream ALU result word valid.
REQ-007 SHALL have port in_ready, output, 1: block can accept a word.
REQ-008 SHALL have port in_data, input, 4*NDIG: hex nibbles, digit 0 in bits [3:0].
REQ-009 SHALL have port in_dp, input, NDIG: decimal-point enable per digit.
REQ-010 SHALL have port seg_n, output, 8: active-low segments {dp,g,f,e,d,c,b,a}.
REQ-011 SHALL have port an_n, output, NDIG: active-low digit enables, at most one low.

Function
REQ-012 SHALL transfer a word when in_valid and in_ready are high on a rising clk edge; in_data and in_dp are captured into a pending register.
REQ-013 SHALL deassert in_ready the cycle after a transfer and hold it low while the pending register is full; in_valid while in_ready is low SHALL be ignored.
REQ-014 SHALL copy pending into the display register only at the frame boundary (last cycle of digit NDIG-1 SHOW), then reassert in_ready the next cycle; no tearing within a frame.
REQ-015 SHALL accept a transfer on the boundary cycle only when pending is empty; that word commits at the following boundary.
REQ-016 SHALL run FSM BLANK -> SHOW -> BLANK per digit: BLANK lasts GAP cycles with an_n all ones and seg_n all ones, SHOW lasts DIV cycles with an_n[idx]=0.
REQ-017 SHALL advance digit index idx 0..NDIG-1 at each SHOW->BLANK transition, wrapping NDIG-1 -> 0.
REQ-018 SHALL drive seg_n during SHOW from the hex decode of display nibble idx (0-F, standard 7-seg glyphs, A-F as A,b,C,d,E,F) and dp from display dp bit idx.
REQ-019 SHALL register seg_n and an_n; both change on the same edge, one cycle after the FSM state change.
REQ-020 SHALL size the cycle counter to ceil(log2(max(DIV,GAP))) bits and never compare across widths truncated.
REQ-021 SHALL scan continuously regardless of handshake activity; frame period NDIG*(GAP+DIV) cycles.

Reset
REQ-022 SHALL on rst: seg_n=8'hFF, an_n all ones, in_ready=1, state=BLANK, idx=0, counter=0, display and pending cleared, pending empty.
REQ-023 SHALL abandon any frame and discard the pending word when rst asserts mid-operation; scanning restarts at digit 0 BLANK after release.

Configuration
REQ-024 SHALL support macro SEG_SCAN_LZB_EN: when defined, leading-zero blanking -- during SHOW, digit idx with nibble 0 and all higher digits 0 and dp bit 0 drives seg_n=8'hFF with an_n still low; digit 0 is never blanked.
REQ-025 SHALL, when SEG_SCAN_LZB_EN is undefined, display all digits including leading zeros.

Structure
REQ-026 SHALL take from package seg_pkg: FSM state typedef (BLANK, SHOW), the 16-entry glyph constant table and SEG_OFF constant 8'hFF.
REQ-027 SHALL instantiate one combinational sub-module seg_hex_dec (4-bit nibble + dp in, 8-bit active-low seg out).

Verification (NDIG=4, DIV=4, GAP=2)
REQ-028 SHALL cover reset: after rst release, first 2 cycles an_n=4'b1111; then an_n=4'b1110, seg_n=8'hC0 ("0") for 4 cycles.
REQ-029 SHALL cover transfer: in_data=16'h12AF accepted mid-frame -> in_ready low until boundary; next frame shows F,A,2,1 on digits 0..3; in_ready high one cycle after boundary.
REQ-030 SHALL cover backpressure: in_valid held with 16'h5555 while pending full -> no capture until in_ready=1, then exactly one transfer.
REQ-031 SHALL cover wrap: 3 consecutive frames -> an_n sequence 1110,1101,1011,0111 repeats, never two bits low, BLANK 2 cycles between each.
REQ-032 SHALL cover LZB: with SEG_SCAN_LZB_EN, in_data=16'h0007, in_dp=0 -> digits 3,2,1 seg_n=8'hFF, digit 0 shows "7"; without macro digits 3..1 show "0".
REQ-033 SHALL cover mid-frame reset: rst during digit 2 SHOW with pending full -> outputs reset values asynchronously, in_ready=1, old pending never displayed.
